// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop adds two WIDTH-bit
// operands and a carry-in LSB first, WIDTH clocks per operation.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;
  logic             bit_s;
  logic             bit_c;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    bit_s     = fa_sum(a_sh[0], b_sh[0], carry);
    bit_c     = fa_carry(a_sh[0], b_sh[0], carry);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operands shift out LSB first, sum bits enter at the MSB end so
  // the result lands aligned after exactly WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= bit_c;
        sum   <= {bit_s, sum[WIDTH-1:1]};
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          cout <= bit_c;
        end
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random 8-bit operations plus an
// exhaustive 4-bit sweep, all compared against plain integer addition.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       s8_start;
  logic [7:0] s8_a;
  logic [7:0] s8_b;
  logic       s8_cin;
  logic       s8_busy;
  logic       s8_done;
  logic [7:0] s8_sum;
  logic       s8_cout;

  logic       s4_start;
  logic [3:0] s4_a;
  logic [3:0] s4_b;
  logic       s4_cin;
  logic       s4_busy;
  logic       s4_done;
  logic [3:0] s4_sum;
  logic       s4_cout;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b), .cin(s8_cin),
    .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b), .cin(s4_cin),
    .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One 8-bit operation; poke > 0 re-asserts start (with other operands)
  // so that it is sampled on accept-relative edge number poke.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      input int poke, input string tag);
    int lat;
    int bc;
    logic [8:0] exp;
    exp = 9'(ia) + 9'(ib) + 9'(ic);
    @(negedge clk);
    s8_start = 1'b1; s8_a = ia; s8_b = ib; s8_cin = ic;
    @(posedge clk); #1;
    s8_start = 1'b0;
    s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom);
    lat = 0;
    bc  = s8_busy ? 1 : 0;
    while (!s8_done && lat < 20) begin
      if (poke > 0 && lat == poke - 1) begin
        s8_start = 1'b1; s8_a = 8'd100; s8_b = 8'd100;
      end else begin
        s8_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (s8_busy) bc++;
    end
    s8_start = 1'b0;
    check_eq({tag, " latency"}, 64'(lat), 64'd8);
    check_eq({tag, " busy_cycles"}, 64'(bc), 64'd8);
    check_eq({tag, " sum"}, 64'(s8_sum), 64'(exp[7:0]));
    check_eq({tag, " cout"}, 64'(s8_cout), 64'(exp[8]));
    check_eq({tag, " busy_at_done"}, 64'(s8_busy), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, " done_clears"}, 64'(s8_done), 64'd0);
  endtask

  task automatic count_done8(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (s8_done) cnt++;
    end
  endtask

  initial begin
    int n;
    int lat;
    int gap;
    logic [4:0] exp4;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0;
    s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_cin = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset busy", 64'(s8_busy), 64'd0);
    check_eq("reset done", 64'(s8_done), 64'd0);
    check_eq("reset sum", 64'(s8_sum), 64'd0);
    check_eq("reset cout", 64'(s8_cout), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run8(8'd23, 8'd19, 1'b0, 0, "add23_19");
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold sum", 64'(s8_sum), 64'd42);
    check_eq("hold cout", 64'(s8_cout), 64'd0);

    run8(8'd255, 8'd1, 1'b0, 0, "add255_1");
    run8(8'd255, 8'd255, 1'b1, 0, "add255_255_c");

    run8(8'd10, 8'd5, 1'b0, 3, "ignored_start");
    count_done8(12, n);
    check_eq("ignored no_extra_done", 64'(n), 64'd0);

    // Start held high; second operands presented in the done cycle.
    @(negedge clk);
    s8_start = 1'b1; s8_a = 8'd1; s8_b = 8'd2; s8_cin = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!s8_done && lat < 30);
    check_eq("b2b first sum", 64'(s8_sum), 64'd3);
    check_eq("b2b first cout", 64'(s8_cout), 64'd0);
    s8_a = 8'd3; s8_b = 8'd4;
    gap = 0;
    do begin
      @(posedge clk); #1; gap++;
    end while (!s8_done && gap < 30);
    s8_start = 1'b0;
    check_eq("b2b second sum", 64'(s8_sum), 64'd7);
    check_eq("b2b gap", 64'(gap), 64'd9);

    repeat (12) @(posedge clk);
    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    s8_start = 1'b1; s8_a = 8'd200; s8_b = 8'd100; s8_cin = 1'b0;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("abort busy", 64'(s8_busy), 64'd0);
    check_eq("abort done", 64'(s8_done), 64'd0);
    check_eq("abort sum", 64'(s8_sum), 64'd0);
    check_eq("abort cout", 64'(s8_cout), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_done8(12, n);
    check_eq("abort no_done", 64'(n), 64'd0);
    run8(8'd1, 8'd1, 1'b0, 0, "after_abort");

    for (int k = 0; k < 25; k++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 0, "random");
    end

    // Exhaustive 4-bit sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          exp4 = 5'(ia + ib + ic);
          @(negedge clk);
          s4_start = 1'b1; s4_a = 4'(ia); s4_b = 4'(ib); s4_cin = 1'(ic);
          @(posedge clk); #1;
          s4_start = 1'b0;
          lat = 0;
          while (!s4_done && lat < 12) begin
            @(posedge clk); #1; lat++;
          end
          check_eq("w4 result", 64'({s4_cout, s4_sum}), 64'(exp4));
          check_eq("w4 latency", 64'(lat), 64'd4);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
